// File: rtl/tst_din_ctrl.sv
// tst_din_ctrl: AIE-domain framed ramp test-data source on an AXI4-Stream master, counting completed frames
module tst_din_ctrl #(
  parameter int DATA_WIDTH      = 128,
  parameter int BEATS_PER_FRAME = 1024
) (
  input  logic                  clk_aie,
  input  logic                  rst_aie,
  input  logic                  test_en_aie,
  input  logic [31:0]           num_frames_aie,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           itecnt_aie,
  output logic                  busy_aie,
  output logic                  done_aie
);
  localparam int LANES = DATA_WIDTH / 32;
  localparam int BW    = $clog2(BEATS_PER_FRAME);
  typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;
  state_t                  state, state_n;
  logic [BW-1:0]           beat, beat_n;
  logic [31:0]             target, target_n, itecnt_n, cnt_inc;
  logic [DATA_WIDTH-1:0]   tdata_n;
  logic                    xfer, last_xfer, hit, valid_n, tlast_n;
  always_comb begin
    xfer      = m_axis_tvalid && m_axis_tready;
    last_xfer = xfer && m_axis_tlast;
    cnt_inc   = itecnt_aie + 32'd1;
    hit       = target != 32'd0 && cnt_inc == target;
    state_n   = state;
    beat_n    = beat;
    itecnt_n  = itecnt_aie;
    target_n  = target;
    case (state)
      IDLE: if (test_en_aie) begin
        state_n  = RUN;
        beat_n   = '0;
        itecnt_n = '0;
        target_n = num_frames_aie;
      end
      RUN, FINISH: if (last_xfer) begin
        beat_n   = '0;
        itecnt_n = cnt_inc;
        state_n  = hit ? DONE : (state == FINISH || !test_en_aie) ? IDLE : RUN;
      end else begin
        beat_n  = xfer ? beat + 1'b1 : beat;
        state_n = test_en_aie ? state : FINISH;
      end
      DONE: state_n = test_en_aie ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
    // Outputs are registered from next-state values so the first beat lands one cycle after enable
    valid_n = state_n == RUN || state_n == FINISH;
    tlast_n = valid_n && beat_n == BW'(BEATS_PER_FRAME - 1);
    tdata_n = '0;
    for (int k = 0; k < LANES; k++)
      tdata_n[32*k +: 32] = valid_n ? {itecnt_n[7:0], 24'(beat_n) * 24'(LANES) + 24'(k)} : 32'd0;
  end
  always_ff @(posedge clk_aie) begin
    if (rst_aie) begin
      state         <= IDLE;
      beat          <= '0;
      target        <= '0;
      itecnt_aie    <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy_aie      <= 1'b0;
      done_aie      <= 1'b0;
    end else begin
      state         <= state_n;
      beat          <= beat_n;
      target        <= target_n;
      itecnt_aie    <= itecnt_n;
      m_axis_tdata  <= tdata_n;
      m_axis_tvalid <= valid_n;
      m_axis_tlast  <= tlast_n;
      busy_aie      <= valid_n;
      done_aie      <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_tst_din_ctrl.sv
// tb_tst_din_ctrl: table, directed and randomized checks of tst_din_ctrl against a run-level reference model
module tb_tst_din_ctrl;
  localparam int DW = 128, BPF = 4, LANES = DW / 32;
  logic clk = 0, rst = 1, en = 0, rdy = 0;
  logic [31:0] nf = 0;
  logic [DW-1:0] tdata;
  logic tvalid, tlast, busy, done;
  logic [31:0] itecnt;
  int checks = 0, failures = 0;
  int m_st = 0, m_beat = 0;
  logic [31:0] m_cnt = 0, m_tgt = 0;
  bit m_rst = 0;
  typedef struct {
    bit en; bit rdy; logic [31:0] nf;
    bit v; bit l; bit d; logic [31:0] cnt; logic [31:0] lane0;
  } vec_t;
  vec_t tab[14];

  always #5 clk = ~clk;

  tst_din_ctrl #(.DATA_WIDTH(DW), .BEATS_PER_FRAME(BPF)) dut (
    .clk_aie(clk), .rst_aie(rst), .test_en_aie(en), .num_frames_aie(nf),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(rdy),
    .m_axis_tlast(tlast), .itecnt_aie(itecnt), .busy_aie(busy), .done_aie(done)
  );

  function automatic logic [DW-1:0] pattern(logic [31:0] cnt, int beat);
    logic [DW-1:0] d;
    for (int k = 0; k < LANES; k++) d[32*k +: 32] = {cnt[7:0], 24'((beat * LANES + k) % (1 << 24))};
    return d;
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    bit stall, valid;
    logic [DW-1:0] pd;
    logic pl;
    stall = tvalid && !rdy && !rst;
    pd = tdata;
    pl = tlast;
    @(posedge clk);
    if (rst) begin
      m_st = 0; m_beat = 0; m_cnt = 0; m_tgt = 0; m_rst = 1;
    end else begin
      m_rst = 0;
      case (m_st)
        0: if (en) begin m_st = 1; m_beat = 0; m_cnt = 0; m_tgt = nf; end
        1, 2: if (rdy && m_beat == BPF - 1) begin
          m_cnt++;
          m_beat = 0;
          if (m_tgt != 0 && m_cnt == m_tgt) m_st = 3;
          else if (m_st == 2 || !en) m_st = 0;
        end else begin
          if (rdy) m_beat++;
          if (!en) m_st = 2;
        end
        default: if (!en) m_st = 0;
      endcase
    end
    #1;
    valid = m_st == 1 || m_st == 2;
    chk("tvalid", tvalid, valid);
    chk("tlast", tlast, valid && m_beat == BPF - 1);
    chk("busy", busy, valid);
    chk("done", done, m_st == 3);
    chk("itecnt", itecnt, m_cnt);
    if (valid) chk("tdata", tdata, pattern(m_cnt, m_beat));
    else if (m_rst) chk("tdata_rst", tdata, 0);
    if (stall) begin
      chk("stall_tdata", tdata, pd);
      chk("stall_tlast", tlast, pl);
    end
  endtask

  initial begin
    tab[0]  = '{1, 1, 3, 1, 0, 0, 0, 32'h00000000};
    tab[1]  = '{1, 1, 3, 1, 0, 0, 0, 32'h00000004};
    tab[2]  = '{1, 1, 3, 1, 0, 0, 0, 32'h00000008};
    tab[3]  = '{1, 1, 3, 1, 1, 0, 0, 32'h0000000C};
    tab[4]  = '{1, 1, 3, 1, 0, 0, 1, 32'h01000000};
    tab[5]  = '{1, 1, 3, 1, 0, 0, 1, 32'h01000004};
    tab[6]  = '{1, 1, 3, 1, 0, 0, 1, 32'h01000008};
    tab[7]  = '{1, 1, 3, 1, 1, 0, 1, 32'h0100000C};
    tab[8]  = '{1, 1, 3, 1, 0, 0, 2, 32'h02000000};
    tab[9]  = '{1, 1, 3, 1, 0, 0, 2, 32'h02000004};
    tab[10] = '{1, 1, 3, 1, 0, 0, 2, 32'h02000008};
    tab[11] = '{1, 1, 3, 1, 1, 0, 2, 32'h0200000C};
    tab[12] = '{1, 1, 3, 0, 0, 1, 3, 32'h00000000};
    tab[13] = '{1, 1, 3, 0, 0, 1, 3, 32'h00000000};
    rst = 1;
    step();
    step();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_itecnt", itecnt, 0);
    chk("rst_tdata", tdata, 0);
    rst = 0;
    step();
    for (int i = 0; i < 14; i++) begin
      en = tab[i].en; rdy = tab[i].rdy; nf = tab[i].nf;
      step();
      chk($sformatf("tab%0d_tvalid", i), tvalid, tab[i].v);
      chk($sformatf("tab%0d_tlast", i), tlast, tab[i].l);
      chk($sformatf("tab%0d_busy", i), busy, tab[i].v);
      chk($sformatf("tab%0d_done", i), done, tab[i].d);
      chk($sformatf("tab%0d_itecnt", i), itecnt, tab[i].cnt);
      if (tab[i].v)
        chk($sformatf("tab%0d_tdata", i), tdata,
            {tab[i].lane0 + 32'd3, tab[i].lane0 + 32'd2, tab[i].lane0 + 32'd1, tab[i].lane0});
    end
    repeat (20) begin
      step();
      chk("done_hold", done, 1);
      chk("done_novalid", tvalid, 0);
    end
    en = 0;
    step();
    chk("done_exit_done", done, 0);
    chk("done_exit_cnt", itecnt, 3);
    en = 1; nf = 0;
    step();
    chk("restart_cnt", itecnt, 0);
    chk("restart_lane0", tdata[31:0], 0);
    for (int i = 0; i < 400 && !(m_cnt == 2 && m_beat == 1); i++) begin
      rdy = $urandom_range(0, 1);
      step();
    end
    chk("t2_reach_cnt", itecnt, 2);
    en = 0;
    for (int i = 0; i < 200 && m_st != 0; i++) begin
      rdy = $urandom_range(0, 1);
      step();
    end
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_cnt", itecnt, 3);
    en = 1; rdy = 1;
    step();
    for (int i = 0; i < 20 && m_beat != BPF - 1; i++) step();
    chk("t3_at_last", tlast, 1);
    en = 0;
    step();
    chk("t3_valid", tvalid, 0);
    chk("t3_cnt", itecnt, 1);
    repeat (3) begin
      step();
      chk("t3_quiet", tvalid, 0);
    end
    en = 1;
    step();
    step();
    rst = 1;
    step();
    chk("t5_rst_valid", tvalid, 0);
    chk("t5_rst_tdata", tdata, 0);
    chk("t5_rst_busy", busy, 0);
    rst = 0;
    step();
    chk("t5_fresh_valid", tvalid, 1);
    chk("t5_fresh_tdata", tdata, pattern(0, 0));
    en = 0; rdy = 1;
    for (int i = 0; i < 20 && m_st != 0; i++) step();
    chk("t6_idle", busy, 0);
    en = 1; rdy = 0; nf = 2;
    repeat (51) begin
      step();
      chk("t6_hold_valid", tvalid, 1);
      chk("t6_hold_tdata", tdata, pattern(0, 0));
      chk("t6_hold_cnt", itecnt, 0);
    end
    for (int i = 0; i < 3000; i++) begin
      rdy = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 49) == 0) en = !en;
      nf = $urandom_range(0, 3);
      rst = $urandom_range(0, 299) == 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
